// File: rtl/mapa_leitor.sv
// mapa_leitor: read-side engine for the game map RAM, shared by collision lookup and free-cell search
//   clk, reset_n                  : clock, asynchronous active-low reset
//   cons_req/x/y/dir              : collision lookup request, head position, move direction
//   cons_ack/prox_x/prox_y/celula : lookup done pulse, next head position, cell content there
//   busca_req/x/y                 : free-cell search request and start cell
//   busca_ack/ok, livre_x/y       : search done pulse, found flag, found cell
//   mem_rd/x/y, mem_dado          : map read strobe, address, data (valid one cycle after mem_rd)
module mapa_leitor #(
    parameter int LARG = 32,
    parameter int ALT  = 24,
    parameter int XW   = $clog2(LARG),
    parameter int YW   = $clog2(ALT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cons_req,
    input  logic [XW-1:0] cons_x,
    input  logic [YW-1:0] cons_y,
    input  logic [1:0]    cons_dir,
    output logic          cons_ack,
    output logic [XW-1:0] cons_prox_x,
    output logic [YW-1:0] cons_prox_y,
    output logic [1:0]    cons_celula,
    input  logic          busca_req,
    input  logic [XW-1:0] busca_x,
    input  logic [YW-1:0] busca_y,
    output logic          busca_ack,
    output logic          busca_ok,
    output logic [XW-1:0] livre_x,
    output logic [YW-1:0] livre_y,
    output logic          mem_rd,
    output logic [XW-1:0] mem_x,
    output logic [YW-1:0] mem_y,
    input  logic [1:0]    mem_dado
);
    localparam int N  = LARG * ALT;
    localparam int CW = $clog2(N + 1);
    localparam logic [XW-1:0] XMAX = XW'(LARG - 1);
    localparam logic [YW-1:0] YMAX = YW'(ALT - 1);

    typedef enum logic [2:0] {OCIOSO, CONS_LE, CONS_AVALIA, BUSCA_LE, BUSCA_AVALIA, FIM} estado_t;

    estado_t       estado, prox;
    logic [XW-1:0] in_x, nx, bx, cur_x, ax;
    logic [YW-1:0] in_y, ny, by, cur_y, ay;
    logic [CW-1:0] cnt, cnt_inc;
    logic          livre, cheio;

    always_comb begin
        in_x    = (cons_x > XMAX) ? '0 : cons_x;
        in_y    = (cons_y > YMAX) ? '0 : cons_y;
        nx      = (cons_dir == 2'd2) ? ((in_x == '0) ? XMAX : in_x - 1'b1) :
                  (cons_dir == 2'd3) ? ((in_x == XMAX) ? '0 : in_x + 1'b1) : in_x;
        ny      = (cons_dir == 2'd0) ? ((in_y == '0) ? YMAX : in_y - 1'b1) :
                  (cons_dir == 2'd1) ? ((in_y == YMAX) ? '0 : in_y + 1'b1) : in_y;
        bx      = (busca_x > XMAX) ? '0 : busca_x;
        by      = (busca_y > YMAX) ? '0 : busca_y;
        // raster order: x first, then y, wrapping from the last cell back to (0,0)
        ax      = (cur_x == XMAX) ? '0 : cur_x + 1'b1;
        ay      = (cur_x != XMAX) ? cur_y : (cur_y == YMAX) ? '0 : cur_y + 1'b1;
        cnt_inc = cnt + 1'b1;
        cheio   = cnt_inc == CW'(N);
        livre   = mem_dado == 2'd0;
        mem_rd  = (estado == CONS_LE) || (estado == BUSCA_LE);
        mem_x   = (estado == CONS_LE) ? cons_prox_x : (estado == BUSCA_LE) ? cur_x : '0;
        mem_y   = (estado == CONS_LE) ? cons_prox_y : (estado == BUSCA_LE) ? cur_y : '0;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:       prox = cons_req ? CONS_LE : busca_req ? BUSCA_LE : OCIOSO;
            CONS_LE:      prox = CONS_AVALIA;
            CONS_AVALIA:  prox = FIM;
            BUSCA_LE:     prox = BUSCA_AVALIA;
            BUSCA_AVALIA: prox = (livre || cheio) ? FIM : BUSCA_LE;
            default:      prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= OCIOSO;
            cons_ack    <= 1'b0;
            cons_prox_x <= '0;
            cons_prox_y <= '0;
            cons_celula <= '0;
            busca_ack   <= 1'b0;
            busca_ok    <= 1'b0;
            livre_x     <= '0;
            livre_y     <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            cnt         <= '0;
        end else begin
            estado    <= prox;
            cons_ack  <= estado == CONS_AVALIA;
            busca_ack <= (estado == BUSCA_AVALIA) && (livre || cheio);
            if (estado == OCIOSO && cons_req) begin
                cons_prox_x <= nx;
                cons_prox_y <= ny;
            end
            if (estado == OCIOSO && !cons_req && busca_req) begin
                cur_x <= bx;
                cur_y <= by;
                cnt   <= '0;
            end
            if (estado == CONS_AVALIA)
                cons_celula <= mem_dado;
            if (estado == BUSCA_AVALIA) begin
                if (livre) begin
                    busca_ok <= 1'b1;
                    livre_x  <= cur_x;
                    livre_y  <= cur_y;
                end else begin
                    cnt   <= cnt_inc;
                    cur_x <= ax;
                    cur_y <= ay;
                    if (cheio) begin
                        busca_ok <= 1'b0;
                        livre_x  <= '0;
                        livre_y  <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mapa_leitor.sv
// tb_mapa_leitor: per-cycle check of mapa_leitor against a queue-based model of its read schedule
module tb_mapa_leitor;
    localparam int LARG = 32;
    localparam int ALT  = 24;
    localparam int XW   = 5;
    localparam int YW   = 5;
    localparam int N    = LARG * ALT;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cons_req = 1'b0;
    logic [XW-1:0] cons_x = '0;
    logic [YW-1:0] cons_y = '0;
    logic [1:0]    cons_dir = '0;
    logic          cons_ack;
    logic [XW-1:0] cons_prox_x;
    logic [YW-1:0] cons_prox_y;
    logic [1:0]    cons_celula;
    logic          busca_req = 1'b0;
    logic [XW-1:0] busca_x = '0;
    logic [YW-1:0] busca_y = '0;
    logic          busca_ack;
    logic          busca_ok;
    logic [XW-1:0] livre_x;
    logic [YW-1:0] livre_y;
    logic          mem_rd;
    logic [XW-1:0] mem_x;
    logic [YW-1:0] mem_y;
    logic [1:0]    mem_dado = '0;

    mapa_leitor #(.LARG(LARG), .ALT(ALT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cons_req(cons_req), .cons_x(cons_x), .cons_y(cons_y), .cons_dir(cons_dir),
        .cons_ack(cons_ack), .cons_prox_x(cons_prox_x), .cons_prox_y(cons_prox_y),
        .cons_celula(cons_celula),
        .busca_req(busca_req), .busca_x(busca_x), .busca_y(busca_y),
        .busca_ack(busca_ack), .busca_ok(busca_ok), .livre_x(livre_x), .livre_y(livre_y),
        .mem_rd(mem_rd), .mem_x(mem_x), .mem_y(mem_y), .mem_dado(mem_dado)
    );

    always #5 clk = ~clk;

    logic [1:0] mapa [ALT][LARG];

    always @(posedge clk)
        mem_dado <= (mem_rd && int'(mem_y) < ALT) ? mapa[mem_y][mem_x] : 2'd0;

    typedef struct {
        bit rd; int mx; int my;
        bit ca; int px; int py; int cel;
        bit ba; bit ok; int lx; int ly;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic exp_t ent(bit rd, int mx, int my);
        exp_t e = '{default: 0};
        e.rd = rd;
        e.mx = mx;
        e.my = my;
        return e;
    endfunction

    always @(negedge clk) if (chk_en) begin
        exp_t e;
        e = (q.size() != 0) ? q.pop_front() : ent(0, 0, 0);
        chk("mem_rd", int'(mem_rd), int'(e.rd));
        chk("mem_x", int'(mem_x), e.mx);
        chk("mem_y", int'(mem_y), e.my);
        chk("cons_ack", int'(cons_ack), int'(e.ca));
        chk("busca_ack", int'(busca_ack), int'(e.ba));
        if (e.ca) begin
            chk("cons_prox_x", int'(cons_prox_x), e.px);
            chk("cons_prox_y", int'(cons_prox_y), e.py);
            chk("cons_celula", int'(cons_celula), e.cel);
        end
        if (e.ba) begin
            chk("busca_ok", int'(busca_ok), int'(e.ok));
            chk("livre_x", int'(livre_x), e.lx);
            chk("livre_y", int'(livre_y), e.ly);
        end
    end

    task automatic push_cons(input int x, input int y, input int d);
        int xs = (x >= LARG) ? 0 : x;
        int ys = (y >= ALT) ? 0 : y;
        int px = (d == 2) ? (xs + LARG - 1) % LARG : (d == 3) ? (xs + 1) % LARG : xs;
        int py = (d == 0) ? (ys + ALT - 1) % ALT : (d == 1) ? (ys + 1) % ALT : ys;
        exp_t e = ent(0, 0, 0);
        q.push_back(ent(1, px, py));
        q.push_back(ent(0, 0, 0));
        e.ca = 1;
        e.px = px;
        e.py = py;
        e.cel = int'(mapa[py][px]);
        q.push_back(e);
        q.push_back(ent(0, 0, 0));
    endtask

    task automatic push_busca(input int x, input int y, output int k);
        int xs = (x >= LARG) ? 0 : x;
        int ys = (y >= ALT) ? 0 : y;
        int start = ys * LARG + xs;
        exp_t e = ent(0, 0, 0);
        k = 0;
        for (int i = 0; i < N; i++) begin
            int c = (start + i) % N;
            q.push_back(ent(1, c % LARG, c / LARG));
            q.push_back(ent(0, 0, 0));
            k++;
            if (mapa[c / LARG][c % LARG] == 2'd0) begin
                e.ok = 1;
                e.lx = c % LARG;
                e.ly = c / LARG;
                break;
            end
        end
        e.ba = 1;
        q.push_back(e);
        q.push_back(ent(0, 0, 0));
    endtask

    task automatic consulta(input int x, input int y, input int d);
        @(posedge clk);
        #1;
        cons_x = x[XW-1:0];
        cons_y = y[YW-1:0];
        cons_dir = d[1:0];
        q.push_back(ent(0, 0, 0));
        push_cons(x, y, d);
        cons_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 cons_req = 1'b0;
    endtask

    task automatic busca(input int x, input int y, output int k);
        @(posedge clk);
        #1;
        busca_x = x[XW-1:0];
        busca_y = y[YW-1:0];
        q.push_back(ent(0, 0, 0));
        push_busca(x, y, k);
        busca_req = 1'b1;
        repeat (2 * k + 2) @(posedge clk);
        #1 busca_req = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cons_ack"}, int'(cons_ack), 0);
        chk({tag, "_cons_prox_x"}, int'(cons_prox_x), 0);
        chk({tag, "_cons_prox_y"}, int'(cons_prox_y), 0);
        chk({tag, "_cons_celula"}, int'(cons_celula), 0);
        chk({tag, "_busca_ack"}, int'(busca_ack), 0);
        chk({tag, "_busca_ok"}, int'(busca_ok), 0);
        chk({tag, "_livre_x"}, int'(livre_x), 0);
        chk({tag, "_livre_y"}, int'(livre_y), 0);
        chk({tag, "_mem_rd"}, int'(mem_rd), 0);
        chk({tag, "_mem_x"}, int'(mem_x), 0);
        chk({tag, "_mem_y"}, int'(mem_y), 0);
    endtask

    initial begin
        int k;
        for (int y = 0; y < ALT; y++)
            for (int x = 0; x < LARG; x++)
                mapa[y][x] = 2'd0;
        mapa[5][6] = 2'd2;
        mapa[23][0] = 2'd1;
        mapa[7][31] = 2'd3;
        mapa[23][30] = 2'd1;
        mapa[23][31] = 2'd1;
        mapa[2][2] = 2'd1;
        #3 chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;

        consulta(5, 5, 3);
        chk("basic_x", int'(cons_prox_x), 6);
        chk("basic_y", int'(cons_prox_y), 5);
        chk("basic_cel", int'(cons_celula), 2);
        consulta(31, 0, 3);
        chk("wrap_r_x", int'(cons_prox_x), 0);
        chk("wrap_r_y", int'(cons_prox_y), 0);
        consulta(0, 0, 0);
        chk("wrap_u_y", int'(cons_prox_y), 23);
        chk("wrap_u_cel", int'(cons_celula), 1);
        consulta(0, 7, 2);
        chk("wrap_l_x", int'(cons_prox_x), 31);
        chk("wrap_l_cel", int'(cons_celula), 3);
        consulta(4, 23, 1);
        chk("wrap_d_x", int'(cons_prox_x), 4);
        chk("wrap_d_y", int'(cons_prox_y), 0);
        consulta(5, 30, 1);
        chk("oor_y", int'(cons_prox_y), 1);

        busca(30, 23, k);
        chk("bwrap_reads", k, 3);
        chk("bwrap_ok", int'(busca_ok), 1);
        chk("bwrap_x", int'(livre_x), 0);
        chk("bwrap_y", int'(livre_y), 0);
        busca(3, 3, k);
        chk("bfirst_reads", k, 1);
        chk("bfirst_x", int'(livre_x), 3);
        chk("bfirst_y", int'(livre_y), 3);

        @(posedge clk);
        #1;
        cons_x = 5'd1; cons_y = 5'd1; cons_dir = 2'd1;
        busca_x = 5'd2; busca_y = 5'd2;
        q.push_back(ent(0, 0, 0));
        push_cons(1, 1, 1);
        push_busca(2, 2, k);
        cons_req = 1'b1;
        busca_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 cons_req = 1'b0;
        repeat (2 * k + 2) @(posedge clk);
        #1 busca_req = 1'b0;
        chk("simul_reads", k, 2);
        chk("simul_cons_y", int'(cons_prox_y), 2);
        chk("simul_livre_x", int'(livre_x), 3);
        chk("simul_livre_y", int'(livre_y), 2);

        for (int y = 0; y < ALT; y++)
            for (int x = 0; x < LARG; x++)
                mapa[y][x] = 2'd1;
        busca(10, 10, k);
        chk("full_reads", k, 768);
        chk("full_ok", int'(busca_ok), 0);
        chk("full_x", int'(livre_x), 0);
        chk("full_y", int'(livre_y), 0);

        chk_en = 1'b0;
        @(posedge clk);
        #1;
        busca_x = 5'd0; busca_y = 5'd0;
        busca_req = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1 chk_zero("abort");
        busca_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_zero("abort_hold");
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        chk_en = 1'b1;
        repeat (12) @(posedge clk);

        mapa[9][8] = 2'd2;
        consulta(8, 10, 0);
        chk("post_rst_cel", int'(cons_celula), 2);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mapa_leitor.md
# mapa_leitor

Read-side engine for the game map RAM. Serves two clients over one synchronous read port: the snake controller (collision lookup of the next head cell) and the fruit controller (search for a free cell to place new fruit). Sits between the map storage, whose write side is driven by the snake and fruit logic, and those two controllers. All sequencing runs in a single FSM.

## Interface

- `LARG`, default 32: map width in cells.
- `ALT`, default 24: map height in cells.
- `XW`, default `$clog2(LARG)`: x coordinate width.
- `YW`, default `$clog2(ALT)`: y coordinate width.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cons_req` input 1: collision lookup request. Level signal, held until `cons_ack`.
- `cons_x` / `cons_y` input XW / YW: current head position.
- `cons_dir` input 2: move direction. 0 = cima (y-1), 1 = baixo (y+1), 2 = esquerda (x-1), 3 = direita (x+1).
- `cons_ack` output 1: one-cycle pulse; result valid.
- `cons_prox_x` / `cons_prox_y` output XW / YW: computed next head position.
- `cons_celula` output 2: cell content at the next position. 0 NADA, 1 COBRA, 2 FRUTA, 3 reserved.
- `busca_req` input 1: free-cell search request. Level signal, held until `busca_ack`.
- `busca_x` / `busca_y` input XW / YW: search start cell.
- `busca_ack` output 1: one-cycle pulse; search finished.
- `busca_ok` output 1: 1 = free cell found; 0 = map full.
- `livre_x` / `livre_y` output XW / YW: found cell; 0 when `busca_ok` = 0.
- `mem_rd` output 1: map read strobe.
- `mem_x` / `mem_y` output XW / YW: read address.
- `mem_dado` input 2: read data, valid in the cycle after `mem_rd`.

## Operation

- **States:** OCIOSO, CONS_LE, CONS_AVALIA, BUSCA_LE, BUSCA_AVALIA, FIM.
- **OCIOSO:** samples requests at each edge. If both are high, `cons_req` wins; `busca_req` stays pending.
- **Out-of-range coordinates:** any input with x ≥ LARG or y ≥ ALT is replaced by 0 on the sampling edge.
- **Consulta path:**
  - Sampling edge registers the next position into `cons_prox_x/y` → CONS_LE.
  - Wrap is toroidal: x-1 at 0 → LARG-1; x+1 at LARG-1 → 0. Same rule for y with ALT.
  - CONS_LE: `mem_rd`=1 with the next position → CONS_AVALIA.
  - CONS_AVALIA: registers `mem_dado` into `cons_celula` and sets `cons_ack` → FIM.
- **Busca path:**
  - Sampling edge loads the cursor with the start cell and clears the cell counter (width `$clog2(LARG*ALT+1)`) → BUSCA_LE.
  - BUSCA_LE: `mem_rd`=1 at the cursor → BUSCA_AVALIA.
  - BUSCA_AVALIA, `mem_dado`==0: register cursor into `livre_x/y`, `busca_ok`=1, `busca_ack`=1 → FIM.
  - BUSCA_AVALIA, otherwise: increment the counter. If the counter reaches LARG*ALT: `busca_ok`=0, `livre_x/y`=0, `busca_ack`=1 → FIM.
  - Otherwise advance the cursor and → BUSCA_LE.
  - Cursor order: x+1; at x=LARG-1, x→0 and y+1; at y=ALT-1 with x=LARG-1, wrap to (0,0).
  - Codes 1, 2 and 3 all count as occupied.
- **FIM:** ack high for this one cycle only; requests are not sampled → OCIOSO.
- **Requester rule:** drop `req` in the cycle after the ack it sees. Result outputs hold until the next ack of the same client.
- **Reset:** `reset_n` low at any time aborts any in-flight operation with no ack → OCIOSO.
- **Reset values:** every output is 0; cursor and counter are 0.

## Timing

- Request sampled at edge E0.
- Consulta:
  - `mem_rd` high E0–E1.
  - `mem_dado` used E1–E2.
  - `cons_ack` and result high E2–E3.
  - Earliest next sampling at E4.
- Busca, found at cell index i (0 = start cell):
  - Cell i read E(2i)–E(2i+1).
  - `busca_ack` high E(2i+2)–E(2i+3).
- Map full: `busca_ack` at E(2·LARG·ALT), i.e. E1536 with the defaults.
- `mem_rd` is never high for two consecutive cycles.
- `mem_x/y` are 0 whenever `mem_rd`=0.

## Test plan

- **Reset:** assert `reset_n`=0 mid-busca. All outputs 0 while low; after release no `busca_ack` appears and the FSM is in OCIOSO.
- **Basic consulta:** (5,5), dir 3, map (6,5)=FRUTA. Exactly one `mem_rd` at (6,5) E0–E1; `cons_ack` at E2 with prox=(6,5), celula=2.
- **Wrap:** (31,0) dir 3 → prox (0,0). (0,0) dir 0 → prox (0,23). (0,7) dir 2 → prox (31,7). (4,23) dir 1 → prox (4,0).
- **Busca wrap:** start (30,23) with (30,23) and (31,23)=COBRA, (0,0)=NADA. Reads at (30,23), (31,23), (0,0); `busca_ack` at E6, ok=1, livre=(0,0).
- **Map full:** all cells = 1, start (10,10). 768 reads, `busca_ack` at E1536, ok=0, livre=(0,0).
- **Simultaneous requests:** `cons_req` and `busca_req` rise together. `cons_ack` at E2. Busca is sampled at E4 (busca_req still held) and its first read occurs E4–E5.
